// File: rtl/ctrl_pipe_buffer.sv
// rtl/ctrl_pipe_buffer.sv - DEPTH-stage valid/ready delay line for the MAC-array control bundle (optional parity: CTRL_PIPE_PARITY_EN)
module ctrl_pipe_buffer #(
    parameter int DEPTH   = 2,
    parameter int SHAMT_W = 5,
    parameter int COL_W   = 2,
    parameter int ROW_W   = 2,
    parameter int ODST_W  = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         FLUSH,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic                         START_CALC_I,
    input  logic                         ILOAD_I,
    input  logic                         WLOAD_I,
    input  logic [SHAMT_W-1:0]           SHAMT_I,
    input  logic [COL_W-1:0]             ICOL_I,
    input  logic [ROW_W-1:0]             WROW_I,
    input  logic [ODST_W-1:0]            ODST_I,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic                         START_CALC_O,
    output logic                         ILOAD_O,
    output logic                         WLOAD_O,
    output logic [SHAMT_W-1:0]           SHAMT_O,
    output logic [COL_W-1:0]             ICOL_O,
    output logic [ROW_W-1:0]             WROW_O,
    output logic [ODST_W-1:0]            ODST_O,
    output logic [$clog2(DEPTH+1)-1:0]   OCC,
    output logic                         PAR_ERR
);

    localparam int DW    = 3 + SHAMT_W + COL_W + ROW_W + ODST_W;
    localparam int OCC_W = $clog2(DEPTH+1);
`ifdef CTRL_PIPE_PARITY_EN
    // Each stage carries one extra bit: even parity of the bundle, stored in the MSB.
    localparam int SW = DW + 1;
`else
    localparam int SW = DW;
`endif

    logic [DW-1:0]    in_bundle;
    logic [SW-1:0]    in_stage;
    logic [SW-1:0]    data_q [DEPTH];
    logic [SW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] ld;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_bundle = {START_CALC_I, ILOAD_I, WLOAD_I, SHAMT_I, ICOL_I, WROW_I, ODST_I};
`ifdef CTRL_PIPE_PARITY_EN
    assign in_stage = {^in_bundle, in_bundle};
`else
    assign in_stage = in_bundle;
`endif

    // Ready ripples from the consumer back to stage 0; an empty stage always accepts, which collapses bubbles.
    always_comb begin
        logic rdy;
        rdy = OUT_READY;
        adv = '0;
        ld  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k] = v_q[k] & rdy;
            ld[k]  = ~v_q[k] | rdy;
            rdy    = ld[k];
        end
    end

    assign IN_READY = ld[0];
    assign in_xfer  = IN_VALID & ld[0];
    assign out_xfer = adv[DEPTH-1];

    // Stage loads: a stage that is empty or emptying takes its upstream neighbour; flush drops only the valids.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (ld[0]) begin
            v_d[0]    = IN_VALID;
            data_d[0] = in_stage;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (ld[k]) begin
                v_d[k]    = adv[k-1];
                data_d[k] = data_q[k-1];
            end
        end
        if (FLUSH) begin
            v_d = '0;
        end
    end

    // Occupancy tracks transfers at the two ends so it always equals the number of valid stages.
    always_comb begin
        occ_d = occ_q;
        if (FLUSH) begin
            occ_d = '0;
        end else if (in_xfer & ~out_xfer) begin
            occ_d = occ_q + 1'b1;
        end else if (~in_xfer & out_xfer) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Pipeline state registers; reset discards everything in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            occ_q  <= occ_d;
            data_q <= data_d;
        end
    end

`ifdef CTRL_PIPE_PARITY_EN
    logic par_err_q;
    logic par_err_d;

    // Recheck parity on every bundle leaving the last stage; any mismatch latches until reset.
    always_comb begin
        par_err_d = par_err_q | (out_xfer & (^data_q[DEPTH-1]));
    end

    // Sticky parity error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign PAR_ERR = par_err_q;
`else
    assign PAR_ERR = 1'b0;
`endif

    assign OUT_VALID = v_q[DEPTH-1];
    assign OCC       = occ_q;
    assign {START_CALC_O, ILOAD_O, WLOAD_O, SHAMT_O, ICOL_O, WROW_O, ODST_O} = data_q[DEPTH-1][DW-1:0];

endmodule

// File: tb/tb_ctrl_pipe_buffer.sv
// tb/tb_ctrl_pipe_buffer.sv - directed self-checking bench for ctrl_pipe_buffer (DEPTH=2 and DEPTH=4 instances)
module tb_ctrl_pipe_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] bin;
    logic        sc, il, wl;
    logic [4:0]  sh;
    logic [1:0]  ic, wr;
    logic [3:0]  od;

    logic        iv2, ord2, ir2, ov2, pe2;
    logic        sc2, il2, wl2;
    logic [4:0]  sh2;
    logic [1:0]  ic2, wr2;
    logic [3:0]  od2;
    logic [1:0]  occ2;
    logic [15:0] bout2;

    logic        iv4, ord4, ir4, ov4, pe4;
    logic        sc4, il4, wl4;
    logic [4:0]  sh4;
    logic [1:0]  ic4, wr4;
    logic [3:0]  od4;
    logic [2:0]  occ4;
    logic [15:0] bout4;

    int passed = 0;
    int total  = 0;

    assign {sc, il, wl, sh, ic, wr, od} = bin;
    assign bout2 = {sc2, il2, wl2, sh2, ic2, wr2, od2};
    assign bout4 = {sc4, il4, wl4, sh4, ic4, wr4, od4};

    always #5 clk = ~clk;

    ctrl_pipe_buffer #(.DEPTH(2)) u2 (
        .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(iv2), .IN_READY(ir2),
        .START_CALC_I(sc), .ILOAD_I(il), .WLOAD_I(wl), .SHAMT_I(sh), .ICOL_I(ic), .WROW_I(wr), .ODST_I(od),
        .OUT_VALID(ov2), .OUT_READY(ord2),
        .START_CALC_O(sc2), .ILOAD_O(il2), .WLOAD_O(wl2), .SHAMT_O(sh2), .ICOL_O(ic2), .WROW_O(wr2), .ODST_O(od2),
        .OCC(occ2), .PAR_ERR(pe2)
    );

    ctrl_pipe_buffer #(.DEPTH(4)) u4 (
        .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(iv4), .IN_READY(ir4),
        .START_CALC_I(sc), .ILOAD_I(il), .WLOAD_I(wl), .SHAMT_I(sh), .ICOL_I(ic), .WROW_I(wr), .ODST_I(od),
        .OUT_VALID(ov4), .OUT_READY(ord4),
        .START_CALC_O(sc4), .ILOAD_O(il4), .WLOAD_O(wl4), .SHAMT_O(sh4), .ICOL_O(ic4), .WROW_O(wr4), .ODST_O(od4),
        .OCC(occ4), .PAR_ERR(pe4)
    );

    function automatic logic [15:0] pat(input int i);
        return {3'b101, 5'(i * 3), 2'(i), 2'(i % 4), 4'(15 - i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int acc;
        logic seen;
        rst = 1'b1; flush = 1'b0; bin = '0;
        iv2 = 1'b0; ord2 = 1'b0; iv4 = 1'b0; ord4 = 1'b0;
        tick();
        tick();
        chk("rst_ov2", 32'(ov2), 32'd0);
        chk("rst_occ2", 32'(occ2), 32'd0);
        chk("rst_bout2", 32'(bout2), 32'd0);
        chk("rst_ir2", 32'(ir2), 32'd1);
        chk("rst_ov4", 32'(ov4), 32'd0);
        chk("rst_occ4", 32'(occ4), 32'd0);
        chk("rst_pe2", 32'(pe2), 32'd0);
        rst = 1'b0;
        tick();

        // single bundle, DEPTH=2, latency 2
        ord2 = 1'b1;
        bin = {1'b1, 1'b1, 1'b0, 5'd17, 2'd2, 2'd3, 4'd9};
        iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        chk("t1_occ_a", 32'(occ2), 32'd1);
        chk("t1_ov_a", 32'(ov2), 32'd0);
        tick();
        chk("t1_ov_b", 32'(ov2), 32'd1);
        chk("t1_bundle", 32'(bout2), 32'h0000_D1B9);
        chk("t1_occ_b", 32'(occ2), 32'd1);
        tick();
        chk("t1_ov_c", 32'(ov2), 32'd0);
        chk("t1_occ_c", 32'(occ2), 32'd0);
        chk("t1_hold", 32'(bout2), 32'h0000_D1B9);

        // eight back-to-back bundles at full throughput
        for (int i = 0; i < 9; i++) begin
            iv2 = (i < 8);
            bin = pat(i);
            chk($sformatf("t2_ir_%0d", i), 32'(ir2), 32'd1);
            tick();
            if (i >= 1) begin
                chk($sformatf("t2_ov_%0d", i), 32'(ov2), 32'd1);
                chk($sformatf("t2_data_%0d", i), 32'(bout2), 32'(pat(i - 1)));
                chk($sformatf("t2_wrow_%0d", i), 32'(wr2), 32'((i - 1) % 4));
            end
        end
        iv2 = 1'b0;
        tick();
        chk("t2_drain_ov", 32'(ov2), 32'd0);
        chk("t2_drain_occ", 32'(occ2), 32'd0);

        // fill against a stalled consumer, then release
        ord2 = 1'b0;
        iv2 = 1'b1;
        acc = 0;
        for (int n = 0; n < 10 && ir2; n++) begin
            bin = pat(20 + acc);
            tick();
            acc++;
        end
        chk("t3_accepted", 32'(acc), 32'd2);
        chk("t3_occ_full", 32'(occ2), 32'd2);
        chk("t3_ir_full", 32'(ir2), 32'd0);
        chk("t3_head", 32'(bout2), 32'(pat(20)));
        bin = pat(22);
        ord2 = 1'b1;
        #1;
        chk("t3_ir_release", 32'(ir2), 32'd1);
        tick();
        iv2 = 1'b0;
        chk("t3_second", 32'(bout2), 32'(pat(21)));
        chk("t3_occ_steady", 32'(occ2), 32'd2);
        tick();
        chk("t3_third", 32'(bout2), 32'(pat(22)));
        chk("t3_ov_third", 32'(ov2), 32'd1);
        chk("t3_occ_one", 32'(occ2), 32'd1);
        tick();
        chk("t3_empty", 32'(ov2), 32'd0);
        chk("t3_occ_zero", 32'(occ2), 32'd0);

        // bubble collapse, DEPTH=4
        ord4 = 1'b0;
        iv4 = 1'b1;
        bin = pat(40);
        tick();
        iv4 = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_ov_head", 32'(ov4), 32'd1);
        chk("t4_occ_one", 32'(occ4), 32'd1);
        chk("t4_head", 32'(bout4), 32'(pat(40)));
        iv4 = 1'b1;
        for (int j = 1; j < 4; j++) begin
            bin = pat(40 + j);
            chk($sformatf("t4_ir_%0d", j), 32'(ir4), 32'd1);
            tick();
        end
        iv4 = 1'b0;
        chk("t4_occ_full", 32'(occ4), 32'd4);
        chk("t4_ir_full", 32'(ir4), 32'd0);
        ord4 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t4_ov_%0d", j), 32'(ov4), 32'd1);
            chk($sformatf("t4_data_%0d", j), 32'(bout4), 32'(pat(40 + j)));
            tick();
        end
        chk("t4_drained", 32'(ov4), 32'd0);
        chk("t4_occ_zero", 32'(occ4), 32'd0);

        // flush with a simultaneous input transfer
        ord4 = 1'b0;
        iv4 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bin = pat(60 + j);
            tick();
        end
        chk("t5_occ_three", 32'(occ4), 32'd3);
        flush = 1'b1;
        bin = pat(63);
        tick();
        flush = 1'b0;
        iv4 = 1'b0;
        chk("t5_occ_flushed", 32'(occ4), 32'd0);
        chk("t5_ov_flushed", 32'(ov4), 32'd0);
        ord4 = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            seen = seen | ov4;
        end
        chk("t5_no_ghost", 32'(seen), 32'd0);
        chk("t5_occ_after", 32'(occ4), 32'd0);

        // asynchronous reset mid-stream
        ord2 = 1'b0;
        iv2 = 1'b1;
        bin = pat(70);
        tick();
        bin = pat(71);
        tick();
        iv2 = 1'b0;
        chk("t6_ov_before", 32'(ov2), 32'd1);
        chk("t6_occ_before", 32'(occ2), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_ov_async", 32'(ov2), 32'd0);
        chk("t6_occ_async", 32'(occ2), 32'd0);
        chk("t6_bundle_async", 32'(bout2), 32'd0);
        ord2 = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_pulse", 32'(ov2), 32'd0);
        chk("t6_ir_after", 32'(ir2), 32'd1);
        chk("t6_pe2", 32'(pe2), 32'd0);
        chk("t6_pe4", 32'(pe4), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
